// File: rtl/ibex_multdiv_iter_pkg.sv
// rtl/ibex_multdiv_iter_pkg.sv - operation and state encodings for the iterative mult/div unit.
package ibex_multdiv_iter_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL,
      MD_OP_MULH,
      MD_OP_DIV,
      MD_OP_REM
   } md_op_e;

   typedef enum logic [1:0] {
      MD_ITER_IDLE,
      MD_ITER_CALC,
      MD_ITER_DONE
   } md_iter_state_e;

   function automatic logic md_is_div(md_op_e op);
      return (op == MD_OP_DIV) || (op == MD_OP_REM);
   endfunction

endpackage

// File: rtl/ibex_multdiv_iter_dp.sv
// rtl/ibex_multdiv_iter_dp.sv - one combinational step: multiply digit accumulate or restoring divide trial subtract.
module ibex_multdiv_iter_dp #(
   parameter int unsigned Width           = 32,
   parameter int unsigned MulBitsPerCycle = 2
) (
   input  logic                 div_op,
   input  logic [2*Width-1:0]   acc,
   input  logic [Width-1:0]     opa,
   input  logic [Width-1:0]     opb,
   output logic [2*Width-1:0]   acc_next
);

   localparam int unsigned K = MulBitsPerCycle;

   logic [Width+K-1:0]   partial;
   logic [Width+K-1:0]   sum;
   logic [2*Width+K-1:0] wide;
   logic [Width:0]       trial;
   logic                 fits;
   logic [Width-1:0]     diff;

   always_comb begin
      partial  = {{K{1'b0}}, opa} * {{Width{1'b0}}, opb[K-1:0]};
      sum      = {{K{1'b0}}, acc[2*Width-1:Width]} + partial;
      wide     = {sum, acc[Width-1:0]};
      // acc = {partial remainder, dividend being shifted out / quotient shifted in}
      trial    = {acc[2*Width-1:Width], acc[Width-1]};
      fits     = trial >= {1'b0, opb};
      diff     = trial[Width-1:0] - opb;
      acc_next = wide[2*Width+K-1:K];
      if (div_op) begin
         acc_next = fits ? {diff, acc[Width-2:0], 1'b1}
                         : {acc[2*Width-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ibex_multdiv_iter.sv
// rtl/ibex_multdiv_iter.sv - iterative multiply/divide unit; IBEX_MULTDIV_ITER_EARLY_OUT_EN enables zero-operand early out.
module ibex_multdiv_iter
   import ibex_multdiv_iter_pkg::*;
#(
   parameter int unsigned Width           = 32,
   parameter int unsigned MulBitsPerCycle = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  md_op_e           op_i,
   input  logic [1:0]       signed_mode_i,
   input  logic [Width-1:0] op_a_i,
   input  logic [Width-1:0] op_b_i,
   input  logic             kill_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [Width-1:0] result_o,
   output logic             busy_o
);

   localparam int unsigned NMul = Width / MulBitsPerCycle;
   localparam int unsigned CntW = $clog2(Width);

   md_iter_state_e     state;
   md_op_e             op_q;
   logic [CntW-1:0]    cnt;
   logic [Width-1:0]   a_q, b_q;
   logic [2*Width-1:0] acc, acc_next;
   logic               neg_q;

   logic               sign_a, sign_b, b_zero, neg_next, last;
   logic [Width-1:0]   a_mag, b_mag, quo, rem, final_res;
   logic [2*Width-1:0] mul_res;

   assign req_ready_o = (state == MD_ITER_IDLE) & ~kill_i;
   assign busy_o      = (state != MD_ITER_IDLE);

   always_comb begin
      sign_a = signed_mode_i[0] & op_a_i[Width-1];
      sign_b = signed_mode_i[1] & op_b_i[Width-1];
      a_mag  = sign_a ? -op_a_i : op_a_i;
      b_mag  = sign_b ? -op_b_i : op_b_i;
      b_zero = (op_b_i == '0);
      case (op_i)
         MD_OP_DIV: neg_next = (sign_a ^ sign_b) & ~b_zero;
         MD_OP_REM: neg_next = sign_a;
         default:   neg_next = sign_a ^ sign_b;
      endcase
   end

   ibex_multdiv_iter_dp #(
      .Width           (Width),
      .MulBitsPerCycle (MulBitsPerCycle)
   ) u_dp (
      .div_op   (md_is_div(op_q)),
      .acc      (acc),
      .opa      (a_q),
      .opb      (b_q),
      .acc_next (acc_next)
   );

   always_comb begin
      last    = md_is_div(op_q) ? (cnt == CntW'(Width - 1)) : (cnt == CntW'(NMul - 1));
      mul_res = neg_q ? -acc_next : acc_next;
      quo     = acc_next[Width-1:0];
      rem     = acc_next[2*Width-1:Width];
      case (op_q)
         MD_OP_MULL: final_res = mul_res[Width-1:0];
         MD_OP_MULH: final_res = mul_res[2*Width-1:Width];
         MD_OP_DIV:  final_res = neg_q ? -quo : quo;
         default:    final_res = neg_q ? -rem : rem;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= MD_ITER_IDLE;
         op_q         <= MD_OP_MULL;
         cnt          <= '0;
         a_q          <= '0;
         b_q          <= '0;
         acc          <= '0;
         neg_q        <= 1'b0;
         result_o     <= '0;
         resp_valid_o <= 1'b0;
      end else if (kill_i) begin
         state        <= MD_ITER_IDLE;
         resp_valid_o <= 1'b0;
      end else begin
         case (state)
            MD_ITER_IDLE: begin
               if (req_valid_i) begin
                  op_q  <= op_i;
                  a_q   <= a_mag;
                  b_q   <= b_mag;
                  neg_q <= neg_next;
                  cnt   <= '0;
                  acc   <= md_is_div(op_i) ? {{Width{1'b0}}, a_mag} : '0;
                  state <= MD_ITER_CALC;
`ifdef IBEX_MULTDIV_ITER_EARLY_OUT_EN
                  if (!md_is_div(op_i) && ((op_a_i == '0) || b_zero)) begin
                     state        <= MD_ITER_DONE;
                     result_o     <= '0;
                     resp_valid_o <= 1'b1;
                  end else if (md_is_div(op_i) && b_zero) begin
                     state        <= MD_ITER_DONE;
                     result_o     <= (op_i == MD_OP_DIV) ? '1 : op_a_i;
                     resp_valid_o <= 1'b1;
                  end
`endif
               end
            end
            MD_ITER_CALC: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (!md_is_div(op_q)) b_q <= b_q >> MulBitsPerCycle;
               if (last) begin
                  state        <= MD_ITER_DONE;
                  result_o     <= final_res;
                  resp_valid_o <= 1'b1;
               end
            end
            MD_ITER_DONE: begin
               if (resp_ready_i) begin
                  state        <= MD_ITER_IDLE;
                  resp_valid_o <= 1'b0;
               end
            end
            default: state <= MD_ITER_IDLE;
         endcase
      end
   end

endmodule
